serial_mag_cmp_ctrl: RTL
========================

// Module: serial_mag_cmp_ctrl
// PURPOSE
//   Sequencer that compares two WIDTH-bit unsigned operands using one 2-bit compare
//   slice per clock. The slice has outputs gt/eq/lt; its logic is embedded in this block.
//   Pairs are walked MSB-first, and the walk terminates early on the first unequal pair.
//   Sits between operand registers and the result/display logic, driven by a start/done handshake.
// PARAMETERS
//   WIDTH  8  operand width in bits; must be even and >= 2 (elaboration error otherwise)
// PORTS
//   clk     in   1                     system clock, rising edge
//   rst_n   in   1                     asynchronous, active-low reset
//   start   in   1                     request a compare; accepted only in IDLE
//   a_in    in   WIDTH                 operand A; sampled on the accepted start edge only
//   b_in    in   WIDTH                 operand B; sampled on the accepted start edge only
//   busy    out  1                     high while in CMP or DONE
//   done    out  1                     single-cycle pulse: result valid
//   gt      out  1                     A > B
//   eq      out  1                     A == B
//   lt      out  1                     A < B
//   steps   out  $clog2(WIDTH/2)+1     number of pairs examined for the last result
// BEHAVIOUR
//   Reset (rst_n=0, async):
//   - state=IDLE; busy, done, gt, eq, lt, steps = 0; internal operand regs and index cleared.
//   - Reset mid-operation aborts immediately, with no partial result.
//   States: IDLE -> CMP -> DONE -> IDLE.
//   IDLE:
//   - start=1 at an edge latches a_in/b_in, sets idx=WIDTH/2-1, clears gt/eq/lt/steps, moves to CMP.
//   CMP (one pair per cycle):
//   - a1a0 = A[2*idx+1:2*idx], b1b0 = B[2*idx+1:2*idx].
//   - Slice equations: gt=(a1&~b1)|(a0&~b1&~b0)|(a1&a0&~b0); eq=(a1~^b1)&(a0~^b0); lt is the mirror of gt.
//   - At each edge, steps increments.
//   - If the pair is unequal: register gt or lt and go to DONE.
//   - Else if idx==0: register eq=1 and go to DONE.
//   - Else: decrement idx and stay in CMP.
//   DONE:
//   - done=1 for exactly one cycle, then the state returns to IDLE.
//   - busy stays 1 during DONE; start is ignored in DONE.
//   Latency:
//   - Start accepted at edge E0; done is high between edges Ek and Ek+1.
//   - k = steps, with 1 <= k <= WIDTH/2.
//   Result holding:
//   - gt/eq/lt/steps hold their values after done until the next accepted start.
//   - Exactly one of gt/eq/lt is 1 whenever steps != 0.
//   start while busy: ignored; operands are not re-sampled and the result is unaffected.
//   a_in/b_in changes after acceptance: no effect.
//   start held high continuously: a new compare begins on the first edge back in IDLE.
// TESTING
//   1. Assert rst_n=0 -> all outputs 0, busy=0. Release reset, start=0 -> outputs stay 0.
//   2. WIDTH=8, a=8'hB4, b=8'h74, start pulse -> done 1 cycle after the start edge; gt=1, steps=1.
//   3. a=8'h5A, b=8'h5B -> lt=1, steps=4, done in the 4th cycle after the start edge.
//   4. a=b=8'hC3 -> eq=1, steps=4. Then a=8'h00, b=8'h40 -> lt=1, steps=1, and the old eq is cleared at start.
//   5. Start with a=8'h10, b=8'h20; pulse start again with a=8'hFF while busy -> lt=1, steps=2; the second start is ignored.
//   6. Drop rst_n during CMP (a=8'h5A, b=8'h5B) -> outputs 0 at once; a new start after release gives the correct lt.

Source files
------------

// File: rtl/serial_mag_cmp_ctrl.sv
// serial_mag_cmp_ctrl: MSB-first serial magnitude comparator, one 2-bit slice per clock
module serial_mag_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a_in,
    input  logic [WIDTH-1:0]           b_in,
    output logic                       busy,
    output logic                       done,
    output logic                       gt,
    output logic                       eq,
    output logic                       lt,
    output logic [$clog2(WIDTH/2):0]   steps
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH/2) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH/2 - 1);

    if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
        $error("serial_mag_cmp_ctrl: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic [1:0]       a_pair, b_pair;
    logic             s_gt, s_eq, s_lt;

    // Compare slice on the pair currently selected by idx
    always_comb begin
        a_pair = a_q[{idx, 1'b0} +: 2];
        b_pair = b_q[{idx, 1'b0} +: 2];
        s_gt   = (a_pair[1] & ~b_pair[1]) | (a_pair[0] & ~b_pair[1] & ~b_pair[0]) |
                 (a_pair[1] & a_pair[0] & ~b_pair[0]);
        s_lt   = (b_pair[1] & ~a_pair[1]) | (b_pair[0] & ~a_pair[1] & ~a_pair[0]) |
                 (b_pair[1] & b_pair[0] & ~a_pair[0]);
        s_eq   = (a_pair[1] ~^ b_pair[1]) & (a_pair[0] ~^ b_pair[0]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: leave CMP on the first unequal pair or after the last pair
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CMP : IDLE;
            CMP:     state_nx = (!s_eq || idx == '0) ? DONE : CMP;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand capture, pair walk and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            steps <= '0;
        end else if (state == IDLE && start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            idx   <= LAST;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            steps <= '0;
        end else if (state == CMP) begin
            steps <= steps + 1'b1;
            if (!s_eq) begin
                gt <= s_gt;
                lt <= s_lt;
            end else if (idx == '0) begin
                eq <= 1'b1;
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end
endmodule
